// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding plus the default frame
// and oversampling constants also used by the phase counter and TX side.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int OVERSAMPLE        = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin synchroniser: SYNC_STAGES flip-flop chain plus one extra stage so the
// receiver can see falling edges. Everything resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rx_prev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s_o    = sync_q[SYNC_STAGES-1];
    assign rx_prev_o = prev_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framing FSM: detects the start edge, re-arms the phase counter,
// shifts data in LSB-first on center_tick and checks the stop bit.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 center_tick,
    output logic                 phase_arm,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int               CNT_W    = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam int               SETTLE   = SYNC_STAGES + 1;

    logic rx_s;
    logic rx_prev;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_i     (rx),
        .rx_s_o   (rx_s),
        .rx_prev_o(rx_prev)
    );

    rx_state_e            state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 phase_arm_q;
    logic [SETTLE-1:0]    settle_q;

    // The synchroniser resets to "high", so a line that is low out of reset
    // would look like a falling edge; edges are ignored until the chain flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            phase_arm_q <= 1'b1;
            settle_q    <= '0;
        end else begin
            settle_q    <= {settle_q[SETTLE-2:0], 1'b1};
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    phase_arm_q <= 1'b1;
                    if (settle_q[SETTLE-1] && rx_prev && !rx_s) begin
                        state_q     <= ST_START;
                        phase_arm_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (center_tick) begin
                        if (!rx_s) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q     <= ST_IDLE;
                            phase_arm_q <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (center_tick) begin
                        shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (center_tick) begin
                        state_q     <= ST_IDLE;
                        phase_arm_q <= 1'b1;
                        if (rx_s) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    phase_arm_q <= 1'b1;
                end
            endcase
        end
    end

    assign phase_arm = phase_arm_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: drives whole serial frames through a behavioural
// phase counter (16x oversampling, baud_en every 4 clk, 64 clk per bit).
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       centerTick;
    logic       phaseArm;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int validCnt = 0;
    int errCnt = 0;
    logic prevPulse = 1'b0;

    always #5 clk = ~clk;

    // Upstream phase counter: held at zero by phase_arm, mid-bit tick on the
    // eighth baud_en after release, then every sixteen.
    logic [1:0] baudDiv;
    logic [3:0] phaseCnt;
    logic       baudEn;
    assign baudEn     = (baudDiv == 2'd3);
    assign centerTick = baudEn && !phaseArm && (phaseCnt == 4'(OVERSAMPLE / 2 - 1));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            baudDiv  <= 2'd0;
            phaseCnt <= 4'd0;
        end else begin
            baudDiv <= baudDiv + 2'd1;
            if (phaseArm)
                phaseCnt <= 4'd0;
            else if (baudEn)
                phaseCnt <= phaseCnt + 4'd1;
        end
    end

    uart_rx_frame #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .center_tick(centerTick),
        .phase_arm  (phaseArm),
        .rx_data    (rxData),
        .rx_valid   (rxValid),
        .frame_err  (frameErr),
        .busy       (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Strobe monitor: counts pulses and enforces single-cycle, mutually exclusive strobes.
    always @(negedge clk) begin
        if (rxValid || frameErr) begin
            checkOutput("pulse_exclusive", 32'(rxValid & frameErr), 32'd0);
            checkOutput("pulse_width", 32'(prevPulse), 32'd0);
        end
        if (rxValid) validCnt++;
        if (frameErr) errCnt++;
        prevPulse = rxValid | frameErr;
    end

    task automatic sendBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
        sendBit(stopBit);
    endtask

    task automatic idleHigh(input int clks);
        if (clks > 0) begin
            rx = 1'b1;
            repeat (clks) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         gapClks;
        int         expValid;
        int         expErr;
        logic [7:0] expData;
    } vec_t;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[4];
        int v0, e0;
        logic [7:0] modelData;
        logic [7:0] rData;
        logic rStop;
        int rGap;

        vecs[0] = '{8'h55, 1'b1, 64, 1, 0, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 0,  1, 0, 8'hA3};
        vecs[2] = '{8'h0F, 1'b1, 64, 1, 0, 8'h0F};
        vecs[3] = '{8'h3C, 1'b0, 0,  0, 1, 8'h0F};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data", 32'(rxData), 32'd0);
        checkOutput("reset_rx_valid", 32'(rxValid), 32'd0);
        checkOutput("reset_frame_err", 32'(frameErr), 32'd0);
        checkOutput("reset_phase_arm", 32'(phaseArm), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Table-driven frames: 0x55, back-to-back 0xA3/0x0F, bad-stop 0x3C
        for (int i = 0; i < 4; i++) begin
            v0 = validCnt;
            e0 = errCnt;
            applyStimulus(vecs[i].data, vecs[i].stopBit);
            checkOutput($sformatf("vec%0d_valid", i), 32'(validCnt - v0), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_err", i), 32'(errCnt - e0), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_data", i), 32'(rxData), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            checkOutput($sformatf("vec%0d_arm", i), 32'(phaseArm), 32'd1);
            idleHigh(vecs[i].gapClks);
        end

        // Break: line stays low after the bad stop bit, no new frame may start
        v0 = validCnt;
        e0 = errCnt;
        for (int i = 0; i < 5; i++) begin
            repeat (BIT_CLKS) @(negedge clk);
            checkOutput($sformatf("break_idle%0d", i), 32'(busy), 32'd0);
        end
        checkOutput("break_valid", 32'(validCnt - v0), 32'd0);
        checkOutput("break_err", 32'(errCnt - e0), 32'd0);
        idleHigh(BIT_CLKS);

        // 20-clk glitch: false start is abandoned silently
        v0 = validCnt;
        e0 = errCnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("glitch_busy", 32'(busy), 32'd1);
        checkOutput("glitch_arm_low", 32'(phaseArm), 32'd0);
        repeat (15) @(negedge clk);
        rx = 1'b1;
        repeat (80) @(negedge clk);
        checkOutput("glitch_idle", 32'(busy), 32'd0);
        checkOutput("glitch_arm_high", 32'(phaseArm), 32'd1);
        checkOutput("glitch_valid", 32'(validCnt - v0), 32'd0);
        checkOutput("glitch_err", 32'(errCnt - e0), 32'd0);
        checkOutput("glitch_data", 32'(rxData), 32'h0F);

        // Asynchronous reset in the middle of data bit 4 of 0xC6
        v0 = validCnt;
        e0 = errCnt;
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        checkOutput("midframe_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rx_data", 32'(rxData), 32'd0);
        checkOutput("async_rx_valid", 32'(rxValid), 32'd0);
        checkOutput("async_phase_arm", 32'(phaseArm), 32'd1);
        checkOutput("async_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        checkOutput("reset_no_valid", 32'(validCnt - v0), 32'd0);
        checkOutput("reset_no_err", 32'(errCnt - e0), 32'd0);
        applyStimulus(8'h81, 1'b1);
        checkOutput("post_reset_valid", 32'(validCnt - v0), 32'd1);
        checkOutput("post_reset_err", 32'(errCnt - e0), 32'd0);
        checkOutput("post_reset_data", 32'(rxData), 32'h81);
        idleHigh(BIT_CLKS);

        // Random frames against a frame-level model: good stop latches the byte,
        // bad stop raises an error and keeps the last good byte.
        modelData = 8'h81;
        for (int i = 0; i < 12; i++) begin
            rData = 8'($urandom);
            rStop = ($urandom_range(0, 3) != 0);
            rGap  = rStop ? int'($urandom_range(0, 100)) : int'($urandom_range(8, 100));
            v0 = validCnt;
            e0 = errCnt;
            applyStimulus(rData, rStop);
            if (rStop) modelData = rData;
            checkOutput($sformatf("rand%0d_valid", i), 32'(validCnt - v0), rStop ? 32'd1 : 32'd0);
            checkOutput($sformatf("rand%0d_err", i), 32'(errCnt - e0), rStop ? 32'd0 : 32'd1);
            checkOutput($sformatf("rand%0d_data", i), 32'(rxData), 32'(modelData));
            checkOutput($sformatf("rand%0d_busy", i), 32'(busy), 32'd0);
            idleHigh(rGap);
        end
        idleHigh(BIT_CLKS);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive framing FSM. It sits directly downstream of the oversampling phase counter and consumes its `center_tick`.
- It also drives the counter's `phase_arm` so the counter re-aligns on every start-bit falling edge.
- It synchronises the raw RX pin, validates the start bit, and shifts in data bits LSB-first. It checks the stop bit and presents a received byte with a one-cycle valid strobe or a framing-error strobe.
- Frame format is 8N1 by default.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8 legal).
- SYNC_STAGES, 2, flip-flop depth of the RX input synchroniser (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  raw serial input, asynchronous to clk, idles high.
- center_tick  in  1  one-clk pulse at the mid-bit sample point, from the phase counter.
- phase_arm  out  1  holds the phase counter at zero while high.
- rx_data  out  DATA_BITS  last correctly framed byte.
- rx_valid  out  1  one-clk pulse: rx_data updated.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, rst=1):
  - All synchroniser stages and rx_prev reset to 1.
  - State goes to IDLE; bit_cnt=0; shift register=0.
  - rx_data=0, rx_valid=0, frame_err=0, phase_arm=1, busy=0.
- Reset mid-frame abandons the frame with no rx_valid or frame_err pulse.
- Synchroniser:
  - rx_s is rx delayed by SYNC_STAGES clks.
  - rx_prev is rx_s delayed by 1 clk.
  - All FSM decisions use rx_s only.
- phase_arm is a registered output: high in IDLE, low in every other state.
- IDLE:
  - A falling edge (rx_prev=1, rx_s=0) moves the FSM to START on the next clk.
  - phase_arm drops in that same clk, so the counter starts counting from zero at the edge.
  - A line held low (break, or low out of reset) never starts a frame until it has gone high and then fallen.
  - center_tick is ignored in IDLE.
- START:
  - On center_tick with rx_s=0: go to DATA, bit_cnt=0.
  - On center_tick with rx_s=1: false start; return to IDLE silently, no strobes.
- DATA:
  - On each center_tick: shift rx_s in as the new MSB, shifting right (LSB-first line order), then bit_cnt++.
  - When the DATA_BITS-th bit is taken (bit_cnt == DATA_BITS-1 before increment): go to STOP.
  - For DATA_BITS<8 the byte is right-aligned in rx_data.
- STOP, on center_tick:
  - rx_s=1: rx_data <= shift register; rx_valid=1 for exactly the next clk; go to IDLE.
  - rx_s=0: frame_err=1 for exactly the next clk; rx_data is unchanged; go to IDLE.
- Latency: rx_valid / frame_err assert 1 clk after the stop-bit center_tick.
- rx_valid and frame_err are never high together, and never high for more than 1 clk.
- Back-to-back frames:
  - IDLE is entered at mid-stop-bit, so a start edge arriving half a bit later is caught.
  - A falling edge present in the same clk that IDLE is entered is detected on the following clk; at most 1 clk of alignment is lost.
- bit_cnt width is clog2(DATA_BITS)+1, and it never wraps.
- Unused state encodings recover to IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_STOP (2 bits);
  - default DATA_BITS and OVERSAMPLE constants shared with the phase counter and the TX side.
- One sub-module: uart_rx_sync (parameterised SYNC_STAGES flip-flop chain, reset value 1, outputs rx_s and rx_prev).

Test Plan:
Bench setup: phase counter instance with OVERSAMPLE=16; baud_en pulses every 4 clk, so 1 bit = 64 clk. SYNC_STAGES=2.
- Frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) -> one rx_valid pulse with rx_data=0x55, frame_err stays 0, busy returns low after the stop center_tick.
- Frames 0xA3 then 0x0F back-to-back, no idle gap -> two rx_valid pulses, rx_data 0xA3 then 0x0F, no frame_err.
- 20-clk low glitch on idle line -> START entered, start center_tick sees 1, return to IDLE; no rx_valid and no frame_err; phase_arm high again.
- Frame 0x3C with stop bit driven 0 -> frame_err single-clk pulse, rx_valid 0, rx_data keeps its previous value (0x0F).
- Line then held low 5 bit-times (break) -> no further frame starts until rx goes high and falls again.
- rst asserted during DATA bit 4 of 0xC6 -> outputs return to reset values immediately (asynchronously); a subsequent clean 0x81 frame is received correctly.
